board_fetch_arbiter: RTL and testbench

BOARD_FETCH_ARBITER -- requirements
Module: board_fetch_arbiter

---
 rtl/board_fetch_arbiter_if.sv | 31 +++
 rtl/board_fetch_arbiter.sv | 172 +++++++++++++++++
 tb/tb_board_fetch_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/board_fetch_arbiter_if.sv
// Board-memory port and game-logic request channel shared by the fetch arbiter.
// master = arbiter side (drives memory, grants game); slave = memory/game side.
interface board_fetch_arbiter_if;
  logic [5:0] mem_addr;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  logic       game_req;
  logic       game_we;
  logic [5:0] game_addr;
  logic [3:0] game_wdata;
  logic       game_gnt;
  logic [3:0] game_rdata;
  logic       game_rvalid;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata,
    input  game_req, game_we, game_addr, game_wdata,
    output game_gnt, game_rdata, game_rvalid
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata,
    output game_req, game_we, game_addr, game_wdata,
    input  game_gnt, game_rdata, game_rvalid
  );
endinterface

// File: rtl/board_fetch_arbiter.sv
// Shares the board memory between a per-line row prefetcher and the game logic; square_* are 1-cycle registered.
// Game requests stall (held until game_gnt) for at most one GAME + FETCH + DRAIN; a missed swap sets sticky underrun.
module board_fetch_arbiter (
  input  logic                         vga_clk,
  input  logic                         reset_n,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  board_fetch_arbiter_if.master        bus,
  output logic [3:0]                   square_code,
  output logic                         square_on,
  output logic                         fetch_busy,
  output logic                         underrun
);

  typedef enum logic [2:0] {IDLE, GAME, FETCH, DRAIN, READY} state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic [2:0]      fetch_row;
  logic [2:0]      cap_col;
  logic            cap_vld;
  logic            pending;
  logic            shadow_full;
  logic [7:0][3:0] shadow;
  logic [7:0][3:0] active;
  logic [3:0]      rdata_hold;

  logic [9:0]      next_y;
  logic            trig;
  logic            swap;
  logic            miss;
  logic            on_c;
  logic [2:0]      row;
  logic [2:0]      col;

  // Inputs never exceed 479 where the result matters, so a compare ladder replaces the divider.
  function automatic logic [2:0] div60(input logic [9:0] v);
    if (v < 10'd60)       return 3'd0;
    else if (v < 10'd120) return 3'd1;
    else if (v < 10'd180) return 3'd2;
    else if (v < 10'd240) return 3'd3;
    else if (v < 10'd300) return 3'd4;
    else if (v < 10'd360) return 3'd5;
    else if (v < 10'd420) return 3'd6;
    else                  return 3'd7;
  endfunction

  assign next_y = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
  assign trig   = (DrawX == 10'd640) && (next_y < 10'd480);
  assign row    = div60(next_y);
  assign col    = div60(DrawX - 10'd80);
  assign swap   = (DrawX == 10'd799) && shadow_full;
  assign miss   = (DrawX == 10'd799) && (next_y < 10'd480) && !shadow_full;
  assign on_c   = (DrawX >= 10'd80) && (DrawX <= 10'd559) && (DrawY < 10'd480);

  // Read data is presented in the rvalid cycle straight from memory, then held.
  assign bus.game_rdata = bus.game_rvalid ? bus.mem_rdata : rdata_hold;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      fetch_row       <= 3'd0;
      cap_col         <= 3'd0;
      cap_vld         <= 1'b0;
      pending         <= 1'b0;
      shadow_full     <= 1'b0;
      shadow          <= '0;
      active          <= '0;
      rdata_hold      <= 4'd0;
      bus.mem_addr    <= 6'd0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_wdata   <= 4'd0;
      bus.game_gnt    <= 1'b0;
      bus.game_rvalid <= 1'b0;
      fetch_busy      <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      bus.mem_addr    <= 6'd0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_wdata   <= 4'd0;
      bus.game_gnt    <= 1'b0;
      bus.game_rvalid <= 1'b0;

      // A fetch read issued this cycle returns next cycle into column cnt.
      cap_vld <= (state == FETCH);
      cap_col <= cnt;
      if (cap_vld)
        shadow[cap_col] <= bus.mem_rdata;
      if (bus.game_rvalid)
        rdata_hold <= bus.mem_rdata;

      if (swap) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end
      if (miss)
        underrun <= 1'b1;

      case (state)
        IDLE, READY: begin
          if (trig || pending) begin
            state         <= FETCH;
            pending       <= 1'b0;
            cnt           <= 3'd0;
            fetch_row     <= row;
            shadow_full   <= 1'b0;
            fetch_busy    <= 1'b1;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= {row, 3'd0};
          end else if (bus.game_req) begin
            state         <= GAME;
            bus.game_gnt  <= 1'b1;
            bus.mem_rd_en <= !bus.game_we;
            bus.mem_wr_en <= bus.game_we;
            bus.mem_addr  <= bus.game_addr;
            bus.mem_wdata <= bus.game_wdata;
          end else if (swap) begin
            state <= IDLE;
          end
        end

        GAME: begin
          pending         <= pending | trig;
          bus.game_rvalid <= bus.mem_rd_en;
          state           <= (shadow_full && !swap) ? READY : IDLE;
        end

        FETCH: begin
          if (cnt == 3'd7) begin
            state <= DRAIN;
          end else begin
            cnt           <= cnt + 3'd1;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= {fetch_row, cnt + 3'd1};
          end
        end

        DRAIN: begin
          fetch_busy  <= 1'b0;
          shadow_full <= 1'b1;
          // Granting straight out of DRAIN keeps the worst-case game wait at 10 cycles.
          if (bus.game_req) begin
            state         <= GAME;
            bus.game_gnt  <= 1'b1;
            bus.mem_rd_en <= !bus.game_we;
            bus.mem_wr_en <= bus.game_we;
            bus.mem_addr  <= bus.game_addr;
            bus.mem_wdata <= bus.game_wdata;
          end else begin
            state <= READY;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      square_on   <= 1'b0;
      square_code <= 4'd0;
    end else begin
      square_on   <= on_c;
      square_code <= on_c ? active[col] : 4'd0;
    end
  end

endmodule

// File: tb/tb_board_fetch_arbiter.sv
// Directed bench for board_fetch_arbiter: prefetch ordering, swap, arbitration, underrun and reset.
module tb_board_fetch_arbiter;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [3:0] square_code;
  logic       square_on;
  logic       fetch_busy;
  logic       underrun;
  logic       mem_load;
  logic [3:0] mem [64];
  int         n_chk = 0;
  int         n_err = 0;

  always #5 vga_clk = ~vga_clk;

  board_fetch_arbiter_if bus();

  board_fetch_arbiter dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .bus         (bus),
    .square_code (square_code),
    .square_on   (square_on),
    .fetch_busy  (fetch_busy),
    .underrun    (underrun)
  );

  // Board memory preloaded with code = low nibble of address; 1-cycle read latency.
  always @(posedge vga_clk) begin
    if (mem_load) begin
      for (int a = 0; a < 64; a++) mem[a] <= 4'(a);
    end else begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge vga_clk);
  endtask

  task automatic set_px(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
  endtask

  // Trigger at DrawX=640 on line y, check the 8 ascending reads from base, then swap at 799.
  task automatic run_fetch(input logic [9:0] y, input logic [5:0] base);
    set_px(10'd639, y);
    cyc();
    set_px(10'd640, y);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k <= 8)
        check("fetch_rd", 32'({bus.mem_rd_en, bus.mem_addr}), 32'({1'b1, base + 6'(k - 1)}));
      else if (k == 9)
        check("drain", 32'({bus.mem_rd_en, fetch_busy}), 32'h1);
      else
        check("fetch_done", 32'(fetch_busy), 32'h0);
      set_px(10'd640 + 10'(k), y);
    end
    set_px(10'd799, y);
    cyc();
    check("swap_no_underrun", 32'(underrun), 32'h0);
    set_px(10'd0, (y == 10'd524) ? 10'd0 : y + 10'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int  n;
    logic seen;

    reset_n        = 1'b0;
    mem_load       = 1'b1;
    bus.game_req   = 1'b0;
    bus.game_we    = 1'b0;
    bus.game_addr  = 6'd0;
    bus.game_wdata = 4'd0;
    set_px(10'd0, 10'd0);
    cyc();
    cyc();
    check("rst_outs", 32'({square_on, square_code, fetch_busy, underrun, bus.mem_rd_en,
                           bus.mem_wr_en, bus.game_gnt, bus.game_rvalid, bus.game_rdata}), 32'h0);
    mem_load = 1'b0;
    reset_n  = 1'b1;
    cyc();

    // Row 1 prefetch from line 59, displayed on line 60.
    run_fetch(10'd59, 6'd8);
    set_px(10'd80, 10'd60);  cyc(); check("sq_x80",  32'({square_on, square_code}), 32'h18);
    set_px(10'd140, 10'd60); cyc(); check("sq_x140", 32'({square_on, square_code}), 32'h19);
    set_px(10'd559, 10'd60); cyc(); check("sq_x559", 32'({square_on, square_code}), 32'h1f);
    set_px(10'd560, 10'd60); cyc(); check("sq_x560", 32'({square_on, square_code}), 32'h00);
    set_px(10'd79, 10'd60);  cyc(); check("sq_x79",  32'({square_on, square_code}), 32'h00);

    // Game read in idle hblank.
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 6'd5;
    set_px(10'd700, 10'd60);
    cyc();
    check("rd_gnt", 32'({bus.game_gnt, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr}), 32'({3'b110, 6'd5}));
    bus.game_req = 1'b0;
    cyc();
    check("rd_rvalid", 32'({bus.game_rvalid, bus.game_gnt, bus.game_rdata}), 32'({2'b10, 4'd5}));
    cyc();
    check("rd_hold", 32'({bus.game_rvalid, bus.game_rdata}), 32'({1'b0, 4'd5}));

    // Trigger lands during GAME: latched and serviced the cycle after.
    set_px(10'd639, 10'd59);
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 6'd2;
    cyc();
    check("pend_gnt", 32'(bus.game_gnt), 32'h1);
    bus.game_req = 1'b0;
    set_px(10'd640, 10'd59);
    cyc();
    check("pend_rvalid", 32'({bus.game_rvalid, bus.game_rdata, bus.mem_rd_en}), 32'({1'b1, 4'd2, 1'b0}));
    set_px(10'd641, 10'd59);
    cyc();
    check("pend_fetch", 32'({fetch_busy, bus.mem_rd_en, bus.mem_addr}), 32'({2'b11, 6'd8}));
    for (int k = 0; k < 9; k++) begin
      set_px(10'd642 + 10'(k), 10'd59);
      cyc();
    end
    set_px(10'd799, 10'd59);
    cyc();
    set_px(10'd0, 10'd60);

    // Game write colliding with the trigger waits for FETCH + DRAIN.
    set_px(10'd639, 10'd59);
    cyc();
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 6'd9; bus.game_wdata = 4'd3;
    set_px(10'd640, 10'd59);
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      cyc();
      n++;
      if (bus.game_gnt) begin
        seen = 1'b1;
        check("wr_port", 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}),
              32'({2'b10, 6'd9, 4'd3}));
      end
      set_px(10'd640 + 10'(n), 10'd59);
    end
    bus.game_req = 1'b0;
    check("wr_wait", 32'(n), 32'd10);
    cyc();
    set_px(10'd799, 10'd59); cyc();
    set_px(10'd140, 10'd60); cyc();
    check("wr_not_yet", 32'(square_code), 32'd9);
    run_fetch(10'd59, 6'd8);
    set_px(10'd140, 10'd60); cyc();
    check("wr_visible", 32'(square_code), 32'd3);

    // Wrap line 524 fetches row 0; line 479 fetches nothing.
    run_fetch(10'd524, 6'd0);
    set_px(10'd559, 10'd0); cyc(); check("row0_x559", 32'(square_code), 32'd7);
    set_px(10'd640, 10'd479); cyc();
    check("no_fetch_479a", 32'({bus.mem_rd_en, fetch_busy}), 32'h0);
    set_px(10'd641, 10'd479); cyc();
    check("no_fetch_479b", 32'({bus.mem_rd_en, fetch_busy}), 32'h0);
    set_px(10'd799, 10'd479); cyc();
    check("no_underrun_479", 32'(underrun), 32'h0);
    set_px(10'd300, 10'd479); cyc(); check("sq_y479", 32'({square_on, square_code}), 32'h13);
    set_px(10'd300, 10'd480); cyc(); check("sq_y480", 32'({square_on, square_code}), 32'h00);
    set_px(10'd300, 10'd524); cyc(); check("sq_y524", 32'({square_on, square_code}), 32'h00);

    // Jump 641 -> 799 mid-fetch.
    set_px(10'd639, 10'd100); cyc();
    set_px(10'd640, 10'd100); cyc();
    set_px(10'd641, 10'd100); cyc();
    set_px(10'd799, 10'd100); cyc();
    check("underrun_set", 32'(underrun), 32'h1);
    set_px(10'd140, 10'd101); cyc();
    check("active_kept", 32'(square_code), 32'd1);
    for (int k = 0; k < 10; k++) begin
      set_px(10'd200 + 10'(k), 10'd101);
      cyc();
    end
    check("underrun_sticky", 32'(underrun), 32'h1);

    // Reset during FETCH.
    set_px(10'd639, 10'd59); cyc();
    set_px(10'd640, 10'd59); cyc();
    cyc();
    check("busy_pre_rst", 32'(fetch_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_async", 32'({fetch_busy, bus.mem_rd_en, underrun, bus.game_gnt}), 32'h0);
    cyc();
    reset_n = 1'b1;
    set_px(10'd80, 10'd60); cyc();
    check("post_rst_sq", 32'({square_on, square_code, underrun}), 32'({1'b1, 4'd0, 1'b0}));
    run_fetch(10'd59, 6'd8);
    set_px(10'd80, 10'd60); cyc();
    check("post_rst_swap", 32'({square_on, square_code}), 32'h18);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
